pwm_wave_sequencer: RTL and testbench

Controller for the up-counting PWM counter of the signal generator. It gates the counter's enable through a programmable prescaler, owns the period and compare values, and steps the compare through a duty-cycle waveform table. Compare updates happen only on period boundaries, so the PWM output never carries a torn period. Supports single-shot or looping playback, per-sample repetition, and graceful stop.

---
 rtl/pwm_wave_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_pwm_wave_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_wave_sequencer.sv
// pwm_wave_sequencer
// Drives an external up-counting PWM counter: a prescaler gates the counter
// enable, the block owns the period and compare values, and it steps the
// compare through a duty-cycle table. Compare changes only happen when the
// counter wraps, so every PWM period is built from a single compare value.
module pwm_wave_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int PW    = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk50m,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_data,
  input  logic [W-1:0]  per_in,
  input  logic [PW-1:0] presc,
  input  logic [AW:0]   len,
  input  logic [7:0]    reps,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  input  logic [W-1:0]  cnt,
  output logic          en,
  output logic [W-1:0]  per,
  output logic [W-1:0]  cmp,
  output logic [AW-1:0] idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Duty-cycle table
  logic [W-1:0] tbl [DEPTH];
  logic         addr_ok;

  // Configuration captured at start; frozen for the whole playback
  logic [PW-1:0] presc_l;
  logic [AW:0]   len_l;
  logic [7:0]    reps_l;
  logic          loop_l;

  // Playback bookkeeping
  logic [PW-1:0] pcnt;
  logic [7:0]    rcnt;
  logic          stop_pend;

  // Decoded conditions
  logic          start_ok;
  logic          bnd;
  logic          last;
  logic          stop_any;
  logic [AW-1:0] nxt_idx;

  // Actions selected by the control process for the coming edge
  logic do_start;
  logic do_rep;
  logic do_adv;
  logic do_wrap;
  logic do_fin;

  // A power-of-two table covers the whole address space, so only other
  // depths need the range check on writes.
  generate
    if (DEPTH == (1 << AW)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = ({1'b0, cfg_addr} < (AW + 1)'(DEPTH));
    end
  endgenerate

  // A start is only accepted with a non-empty, in-range length and a
  // non-zero period; anything else would leave the counter without a wrap.
  assign start_ok = start && (len != '0) && (len <= (AW + 1)'(DEPTH)) && (per_in != '0);

  // The enable is decoded straight from registers so it never glitches.
  assign en = (state == RUN) && (pcnt == presc_l);

  // The counter wraps on the enabled cycle where it sits at per-1.
  assign bnd = en && (cnt >= (per - W'(1)));

  assign last     = ({1'b0, idx} == (len_l - (AW + 1)'(1)));
  assign stop_any = stop_pend | stop;
  assign nxt_idx  = idx + AW'(1);

  // State register
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and action decode; the period boundary is the only place
  // the sample, repetition or termination can change.
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_rep    = 1'b0;
    do_adv    = 1'b0;
    do_wrap   = 1'b0;
    do_fin    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          do_start  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bnd) begin
          if (stop_any) begin
            do_fin = 1'b1;
          end else if (rcnt < reps_l) begin
            do_rep = 1'b1;
          end else if (!last) begin
            do_adv = 1'b1;
          end else if (loop_l) begin
            do_wrap = 1'b1;
          end else begin
            do_fin = 1'b1;
          end
        end
        if (do_fin) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Table storage; writes are allowed at any time, and a load on the same
  // edge sees the value from before the write.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else if (cfg_we && addr_ok) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // Latch playback configuration on an accepted start only
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      presc_l <= '0;
      len_l   <= '0;
      reps_l  <= '0;
      loop_l  <= 1'b0;
      per     <= '0;
    end else if (do_start) begin
      presc_l <= presc;
      len_l   <= len;
      reps_l  <= reps;
      loop_l  <= loop;
      per     <= per_in;
    end
  end

  // Prescaler: counts 0..presc while running, restarting on each start
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (do_start || do_fin) begin
      pcnt <= '0;
    end else if (state == RUN) begin
      if (pcnt == presc_l) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  // Repetition counter: counts extra periods of the current sample
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
    end else if (do_start || do_adv || do_wrap || do_fin) begin
      rcnt <= '0;
    end else if (do_rep) begin
      rcnt <= rcnt + 8'd1;
    end
  end

  // A stop request is remembered until the next boundary ends playback
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      stop_pend <= 1'b0;
    end else if (do_start || do_fin) begin
      stop_pend <= 1'b0;
    end else if ((state == RUN) && stop) begin
      stop_pend <= 1'b1;
    end
  end

  // Index and compare: loaded at start, stepped or wrapped on a boundary,
  // and cleared when playback finishes so the output idles low.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      idx <= '0;
      cmp <= '0;
    end else if (do_start) begin
      idx <= '0;
      cmp <= tbl[0];
    end else if (do_adv) begin
      idx <= nxt_idx;
      cmp <= tbl[nxt_idx];
    end else if (do_wrap) begin
      idx <= '0;
      cmp <= tbl[0];
    end else if (do_fin) begin
      cmp <= '0;
    end
  end

  // Status flags: busy spans the running state, done marks the finish cycle
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= do_fin;
      if (do_start) begin
        busy <= 1'b1;
      end else if (do_fin) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_wave_sequencer.sv
// Testbench for pwm_wave_sequencer: a behavioural playback model plus a
// modelled PWM counter, directed scenarios and a randomized soak.
module tb_pwm_wave_sequencer;

  localparam int W = 8;
  localparam int DEPTH = 16;
  localparam int PW = 16;
  localparam int AW = 4;

  logic          clk50m = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [W-1:0]  cfg_data;
  logic [W-1:0]  per_in;
  logic [PW-1:0] presc;
  logic [AW:0]   len;
  logic [7:0]    reps;
  logic          loop;
  logic          start;
  logic          stop;
  logic [W-1:0]  cnt;
  logic          en;
  logic [W-1:0]  per;
  logic [W-1:0]  cmp;
  logic [AW-1:0] idx;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Behavioural model state: playback is described by elapsed clocks since
  // start, from which enable count, period count and sample number follow.
  bit m_run, m_fin, m_stop;
  int m_t, m_per, m_presc, m_len, m_reps, m_loop, m_idx, m_cmp;
  int m_tbl [DEPTH];

  pwm_wave_sequencer #(.W(W), .DEPTH(DEPTH), .PW(PW)) dut (
    .clk50m(clk50m), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .per_in(per_in), .presc(presc), .len(len),
    .reps(reps), .loop(loop), .start(start), .stop(stop), .cnt(cnt),
    .en(en), .per(per), .cmp(cmp), .idx(idx), .busy(busy), .done(done)
  );

  always #5 clk50m = ~clk50m;

  // The PWM counter being controlled: counts on en, wraps at per-1
  always @(posedge clk50m or posedge rst) begin
    if (rst) cnt <= '0;
    else if (en) cnt <= (cnt >= per - 8'd1) ? 8'd0 : cnt + 8'd1;
  end

  task automatic model_reset();
    m_run = 0; m_fin = 0; m_stop = 0; m_t = 0; m_per = 0; m_presc = 0;
    m_len = 0; m_reps = 0; m_loop = 0; m_idx = 0; m_cmp = 0;
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 0;
  endtask

  function automatic bit m_en();
    return m_run && ((m_t % (m_presc + 1)) == m_presc);
  endfunction

  // Model reaction to the coming clock edge with the current inputs
  task automatic model_edge();
    int e, p, q, nidx;
    bit fin, adv;
    if (rst) begin model_reset(); return; end
    if (m_fin) begin
      m_fin = 0;
    end else if (!m_run) begin
      if (start && len >= 1 && len <= DEPTH && per_in != 0) begin
        m_run = 1; m_t = 0; m_idx = 0; m_cmp = m_tbl[0]; m_stop = 0;
        m_per = per_in; m_presc = presc; m_len = len; m_reps = reps; m_loop = loop;
      end
    end else begin
      fin = 0; adv = 0; nidx = 0;
      if (m_en()) begin
        e = (m_t + 1) / (m_presc + 1);
        if (e % m_per == 0) begin
          p = e / m_per;
          if (m_stop || stop) fin = 1;
          else if (p % (m_reps + 1) == 0) begin
            q = p / (m_reps + 1);
            if (!m_loop && q == m_len) fin = 1;
            else begin adv = 1; nidx = q % m_len; end
          end
        end
      end
      if (fin) begin
        m_run = 0; m_fin = 1; m_cmp = 0; m_stop = 0;
      end else begin
        if (stop) m_stop = 1;
        if (adv) begin m_idx = nidx; m_cmp = m_tbl[nidx]; end
        m_t++;
      end
    end
    if (cfg_we) m_tbl[cfg_addr] = cfg_data;
  endtask

  task automatic checkOutput();
    logic [W-1:0] e_per, e_cmp;
    logic [AW-1:0] e_idx;
    logic e_en;
    e_en = m_en(); e_per = m_per[W-1:0]; e_cmp = m_cmp[W-1:0]; e_idx = m_idx[AW-1:0];
    tests++;
    if ({en, per, cmp, idx, busy, done} !== {e_en, e_per, e_cmp, e_idx, m_run, m_fin}) begin
      fails++;
      $display("[TB] FAIL cycle %0d outputs: got en=%b per=%0d cmp=%0d idx=%0d busy=%b done=%b, want en=%b per=%0d cmp=%0d idx=%0d busy=%b done=%b",
               cyc, en, per, cmp, idx, busy, done, e_en, e_per, e_cmp, e_idx, m_run, m_fin);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock: model steps, DUT steps, outputs compared just after the edge
  task automatic applyStimulus();
    model_edge();
    @(posedge clk50m);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic writeEntry(input int a, input int d);
    cfg_we = 1; cfg_addr = a[AW-1:0]; cfg_data = d[W-1:0];
    applyStimulus();
    cfg_we = 0;
  endtask

  task automatic startRun(input int p, input int ps, input int l, input int r, input bit lp);
    per_in = p[W-1:0]; presc = ps[PW-1:0]; len = l[AW:0]; reps = r[7:0]; loop = lp;
    start = 1;
    applyStimulus();
    start = 0;
  endtask

  task automatic asyncReset();
    #2 rst = 1;
    #1 model_reset();
    checkOutput();
  endtask

  initial begin
    int n1, n2, n3, nen, done_at, done_cnt, idx_at_done, k;
    bit found;
    rst = 1; cfg_we = 0; cfg_addr = 0; cfg_data = 0; per_in = 0; presc = 0;
    len = 0; reps = 0; loop = 0; start = 0; stop = 0;
    model_reset();
    @(posedge clk50m); #1;
    checkOutput();
    checkValue("reset_en", en, 0);
    checkValue("reset_cmp", cmp, 0);
    checkValue("reset_busy", busy, 0);
    applyStimulus();
    rst = 0;
    applyStimulus();

    // Single-shot playback of three samples
    writeEntry(0, 10); writeEntry(1, 20); writeEntry(2, 30);
    startRun(50, 0, 3, 0, 0);
    n1 = 0; n2 = 0; n3 = 0; done_at = -1; done_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      if (cmp == 10) n1++;
      if (cmp == 20) n2++;
      if (cmp == 30) n3++;
      if (done) begin done_at = i; done_cnt++; end
      applyStimulus();
    end
    checkValue("ss_cmp10_cycles", n1, 50);
    checkValue("ss_cmp20_cycles", n2, 50);
    checkValue("ss_cmp30_cycles", n3, 50);
    checkValue("ss_done_cycle", done_at, 150);
    checkValue("ss_done_count", done_cnt, 1);
    checkValue("ss_busy_after", busy, 0);

    // Prescaler and per-sample repetition
    writeEntry(0, 1); writeEntry(1, 3);
    startRun(4, 3, 2, 1, 0);
    n1 = 0; n3 = 0; nen = 0; done_at = -1;
    for (int i = 0; i < 70; i++) begin
      if (i < 64 && en) nen++;
      if (cmp == 1) n1++;
      if (cmp == 3) n3++;
      if (done) done_at = i;
      applyStimulus();
    end
    checkValue("pr_en_count", nen, 16);
    checkValue("pr_cmp1_cycles", n1, 32);
    checkValue("pr_cmp3_cycles", n3, 32);
    checkValue("pr_done_cycle", done_at, 64);

    // Looping playback stopped mid-period
    writeEntry(0, 5); writeEntry(1, 7);
    startRun(10, 0, 2, 0, 1);
    n2 = 0; done_at = -1; idx_at_done = -1;
    for (int i = 0; i < 66; i++) begin
      if (i == 53) begin
        checkValue("ls_cnt_at_stop", cnt, 3);
        stop = 1;
      end
      if (i >= 53 && i <= 59 && cmp == 7) n2++;
      if (done) begin done_at = i; idx_at_done = idx; end
      applyStimulus();
      stop = 0;
    end
    checkValue("ls_cmp7_stopped_period", n2, 7);
    checkValue("ls_done_cycle", done_at, 60);
    checkValue("ls_idx_at_done", idx_at_done, 1);

    // Illegal starts leave everything as it was
    startRun(77, 0, 0, 0, 0);
    checkValue("il_len0_busy", busy, 0);
    checkValue("il_len0_per", per, 10);
    startRun(0, 0, 2, 0, 0);
    checkValue("il_per0_busy", busy, 0);
    startRun(6, 1, 2, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus();
    startRun(99, 0, 9, 3, 1);
    checkValue("il_busy_start_per", per, 6);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (done) found = 1;
      applyStimulus();
    end
    checkValue("il_run_finishes", found, 1);
    for (int i = 0; i < 3; i++) applyStimulus();

    // Live table writes: on the boundary edge (old value) and one earlier
    writeEntry(0, 11); writeEntry(1, 22);
    startRun(4, 0, 2, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus();
    cfg_we = 1; cfg_addr = 1; cfg_data = 33;
    applyStimulus();
    cfg_we = 0;
    checkValue("lw_same_edge_old", cmp, 22);
    for (int i = 0; i < 6; i++) applyStimulus();
    startRun(4, 0, 2, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus();
    cfg_we = 1; cfg_addr = 1; cfg_data = 44;
    applyStimulus();
    cfg_we = 0;
    applyStimulus();
    checkValue("lw_early_new", cmp, 44);
    for (int i = 0; i < 6; i++) applyStimulus();

    // Reset in the middle of a looping run
    for (int i = 0; i < 5; i++) writeEntry(i, 40 + i);
    startRun(3, 0, 5, 0, 1);
    found = 0;
    for (k = 0; k < 200 && !found; k++) begin
      if (idx == 3) found = 1;
      else applyStimulus();
    end
    checkValue("rs_reached_idx3", found, 1);
    asyncReset();
    checkValue("rs_idx", idx, 0);
    checkValue("rs_cmp", cmp, 0);
    checkValue("rs_busy", busy, 0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      if (done) done_cnt++;
    end
    rst = 0;
    startRun(2, 0, 5, 0, 0);
    n1 = 0;
    for (int i = 0; i < 14; i++) begin
      if (cmp != 0) n1++;
      if (done) done_cnt++;
      applyStimulus();
    end
    checkValue("rs_table_cleared", n1, 0);
    checkValue("rs_done_after_cleared_run", done_cnt, 1);

    // Randomized soak against the model
    for (int i = 0; i < 4000; i++) begin
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_addr = AW'($urandom_range(0, DEPTH - 1));
      cfg_data = W'($urandom_range(0, 255));
      per_in = W'($urandom_range(0, 6));
      presc = PW'($urandom_range(0, 2));
      len = (AW + 1)'($urandom_range(0, 18));
      reps = 8'($urandom_range(0, 2));
      loop = $urandom_range(0, 1);
      start = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        asyncReset();
        applyStimulus();
        rst = 0;
      end else begin
        applyStimulus();
      end
    end
    cfg_we = 0; start = 0; stop = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
